// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern generator: mode encoding and
// the geometry of the square, bar and checker patterns.
package pattern_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE  = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_GRAD    = 2'd3
  } mode_t;

  localparam int SQ_SIZE   = 256;
  localparam int BAR_SHIFT = 6;
  localparam int CHK_SHIFT = 5;

  // Modes cycle SQUARE -> BARS -> CHECKER -> GRAD -> SQUARE.
  function automatic mode_t mode_succ(input mode_t m);
    logic [1:0] n;
    n = m + 2'd1;
    return mode_t'(n);
  endfunction

endpackage

// File: rtl/pattern_gen_272p_if.sv
// Video bus for the pattern generator: display timing in, delayed timing
// and RGB colour out.
interface pattern_gen_272p_if #(
  parameter int CORDW = 10,
  parameter int RW    = 5,
  parameter int GW    = 6,
  parameter int BW    = 5
);
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic             out_hsync;
  logic             out_vsync;
  logic             out_de;
  logic [RW-1:0]    out_r;
  logic [GW-1:0]    out_g;
  logic [BW-1:0]    out_b;

  modport master (
    output sx, sy, hsync, vsync, de,
    input  out_hsync, out_vsync, out_de, out_r, out_g, out_b
  );

  modport slave (
    input  sx, sy, hsync, vsync, de,
    output out_hsync, out_vsync, out_de, out_r, out_g, out_b
  );
endinterface

// File: rtl/pattern_mode_ctl.sv
// Frame counter and pattern mode sequencer; a mode request is held pending
// and only applied at the next frame start so the mode never changes mid-frame.
module pattern_mode_ctl
  import pattern_pkg::*;
#(
  parameter int CORDW = 10
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             mode_next,
  output mode_t            mode,
  output logic [7:0]       frame_cnt
);

  mode_t      mode_q, mode_d;
  logic       pend_q, pend_d;
  logic [7:0] fc_q, fc_d;
  logic       frame_start;

  assign frame_start = (sx == '0) && (sy == '0);

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      mode_q <= MODE_SQUARE;
      pend_q <= 1'b0;
      fc_q   <= 8'd0;
    end else begin
      mode_q <= mode_d;
      pend_q <= pend_d;
      fc_q   <= fc_d;
    end
  end

  // A request arriving on a frame start that finds nothing pending only arms
  // the flag; one arriving while already pending is dropped.
  always_comb begin
    mode_d = mode_q;
    pend_d = pend_q;
    fc_d   = fc_q;
    if (frame_start) begin
      fc_d = fc_q + 8'd1;
    end
    if (frame_start && pend_q) begin
      mode_d = mode_succ(mode_q);
      pend_d = 1'b0;
    end else if (mode_next) begin
      pend_d = 1'b1;
    end
  end

  assign mode      = mode_q;
  assign frame_cnt = fc_q;

endmodule

// File: rtl/pattern_gen_272p.sv
// Two-stage test pattern generator (square, bars, checker, gradient).
// Define PATTERN_ANIM_EN to scroll modes 1-3 horizontally by frame_cnt.
module pattern_gen_272p
  import pattern_pkg::*;
#(
  parameter int CORDW = 10,
  parameter int RW    = 5,
  parameter int GW    = 6,
  parameter int BW    = 5
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  pattern_gen_272p_if.slave       vid,
  input  logic                    mode_next,
  output logic [1:0]              mode,
  output logic [7:0]              frame_cnt
);

  mode_t      mode_w;
  logic [7:0] fc_w;

  pattern_mode_ctl #(.CORDW(CORDW)) u_mode_ctl (
    .clk_pix   (clk_pix),
    .rst_pix   (rst_pix),
    .sx        (vid.sx),
    .sy        (vid.sy),
    .mode_next (mode_next),
    .mode      (mode_w),
    .frame_cnt (fc_w)
  );

  assign mode      = mode_w;
  assign frame_cnt = fc_w;

  // Left-justify a sw-bit source into a w-bit channel.
  function automatic logic [15:0] fit(input logic [7:0] v, input int sw, input int w);
    if (w >= sw) return 16'(v) << (w - sw);
    else         return 16'(v) >> (sw - w);
  endfunction

`ifdef PATTERN_ANIM_EN
  function automatic logic [7:0] scroll(input logic [CORDW-1:0] s, input logic [7:0] f);
    logic [CORDW-1:0] t;
    t = s + CORDW'(f);
    return t[8:1];
  endfunction
`endif

  // Only px[8:1], sx[7:4] and sy[7:4] feed the patterns; the square test is
  // resolved here so the full coordinates need not be carried forward.
  logic [8:1] px_p1;
  logic [7:4] sxn_p1;
  logic [7:4] sy_p1;
  logic       sq_p1;
  logic       hs_p1, vs_p1, vld_p1;

  // Stage 1: pattern coordinate and timing
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      px_p1  <= '0;
      sxn_p1 <= '0;
      sy_p1  <= '0;
      sq_p1  <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
`ifdef PATTERN_ANIM_EN
      px_p1  <= scroll(vid.sx, fc_w);
`else
      px_p1  <= vid.sx[8:1];
`endif
      sxn_p1 <= vid.sx[7:4];
      sy_p1  <= vid.sy[7:4];
      sq_p1  <= (int'(vid.sx) < SQ_SIZE) && (int'(vid.sy) < SQ_SIZE);
      hs_p1  <= vid.hsync;
      vs_p1  <= vid.vsync;
      vld_p1 <= vid.de;
    end
  end

  logic [RW-1:0] r_c;
  logic [GW-1:0] g_c;
  logic [BW-1:0] b_c;
  logic [2:0]    bar_idx;
  logic          chk_on;

  assign bar_idx = px_p1[BAR_SHIFT+2:BAR_SHIFT];
  assign chk_on  = px_p1[CHK_SHIFT] ^ sy_p1[CHK_SHIFT];

  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    unique case (mode_w)
      MODE_SQUARE: begin
        if (sq_p1) begin
          r_c = RW'(fit({4'h0, sxn_p1}, 4, RW));
          g_c = GW'(fit({4'h0, sy_p1}, 4, GW));
          b_c = BW'(fit(8'h04, 4, BW));
        end
      end
      MODE_BARS: begin
        r_c = {RW{bar_idx[2]}};
        g_c = {GW{bar_idx[1]}};
        b_c = {BW{bar_idx[0]}};
      end
      MODE_CHECKER: begin
        r_c = {RW{chk_on}};
        g_c = {GW{chk_on}};
        b_c = {BW{chk_on}};
      end
      MODE_GRAD: begin
        r_c = RW'(fit(px_p1, 8, RW));
        g_c = GW'(fit(px_p1, 8, GW));
        b_c = BW'(fit(px_p1, 8, BW));
      end
      default: ;
    endcase
  end

  logic [RW-1:0] r_p2;
  logic [GW-1:0] g_p2;
  logic [BW-1:0] b_p2;
  logic          hs_p2, vs_p2, vld_p2;

  // Stage 2: colour with blanking
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_p2   <= '0;
      g_p2   <= '0;
      b_p2   <= '0;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      r_p2   <= vld_p1 ? r_c : '0;
      g_p2   <= vld_p1 ? g_c : '0;
      b_p2   <= vld_p1 ? b_c : '0;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      vld_p2 <= vld_p1;
    end
  end

  assign vid.out_r     = r_p2;
  assign vid.out_g     = g_p2;
  assign vid.out_b     = b_p2;
  assign vid.out_hsync = hs_p2;
  assign vid.out_vsync = vs_p2;
  assign vid.out_de    = vld_p2;

endmodule
